// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants for the pipeline stall controller: stall vector encodings,
// multi-cycle sequencer states and the request-priority helper.
package pipeline_stall_controller_pkg;

    localparam int SIGNAL_BUS = 6;

    // Bit n set means stage n is held; the buffer after the highest set bit bubbles.
    localparam logic [SIGNAL_BUS-1:0] STALL_NONE = 6'b000000;
    localparam logic [SIGNAL_BUS-1:0] STALL_IF   = 6'b000011;
    localparam logic [SIGNAL_BUS-1:0] STALL_ID   = 6'b000111;
    localparam logic [SIGNAL_BUS-1:0] STALL_EX   = 6'b001111;
    localparam logic [SIGNAL_BUS-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    function automatic logic [SIGNAL_BUS-1:0] stall_vector(
        input logic flush,
        input logic if_req,
        input logic id_req,
        input logic ex_req,
        input logic mem_req
    );
        logic [SIGNAL_BUS-1:0] vec;
        vec = STALL_NONE;
        if (flush) begin
            vec = STALL_NONE;
        end else if (mem_req) begin
            vec = STALL_MEM;
        end else if (ex_req) begin
            vec = STALL_EX;
        end else if (id_req) begin
            vec = STALL_ID;
        end else if (if_req) begin
            vec = STALL_IF;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_stall_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module stall_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall vector arbiter with EX multi-cycle sequencer, stall-cycle
// performance counter and stuck-pipeline watchdog.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CYCLE_WIDTH    = 6,
    parameter int WATCHDOG_LIMIT = 1024,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   if_stall_request,
    input  logic                   id_stall_request,
    input  logic                   ex_stall_request,
    input  logic                   mem_stall_request,
    input  logic                   ex_multicycle_start,
    input  logic [CYCLE_WIDTH-1:0] ex_multicycle_cycles,
    output logic                   ex_multicycle_done,
    output logic                   ex_busy,
    output logic [SIGNAL_BUS-1:0]  stall,
    input  logic                   perf_clear,
    output logic [PERF_WIDTH-1:0]  stall_cycles,
    output logic                   stall_timeout
);

    mc_state_e              state_q, state_d;
    logic [CYCLE_WIDTH-1:0] cnt_q, cnt_d;
    logic                   ex_multicycle_done_q, ex_multicycle_done_d;
    logic                   ex_busy_q, ex_busy_d;
    logic                   stall_timeout_q, stall_timeout_d;

    logic [CYCLE_WIDTH-1:0] cycles_eff;
    logic                   start_accept;
    logic                   ex_req_eff;
    logic                   stall_any;
    logic                   timeout_set;

    // A zero-length op still occupies EX for one cycle.
    assign cycles_eff = (ex_multicycle_cycles == '0) ? CYCLE_WIDTH'(1) : ex_multicycle_cycles;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_accept = 1'b0;
        if (flush) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (ex_multicycle_start) begin
                        start_accept = 1'b1;
                        cnt_d        = cycles_eff - CYCLE_WIDTH'(1);
                        state_d      = (cycles_eff > CYCLE_WIDTH'(1)) ? MC_BUSY : MC_DONE;
                    end
                end
                MC_BUSY: begin
                    cnt_d = cnt_q - CYCLE_WIDTH'(1);
                    if (cnt_q == CYCLE_WIDTH'(1)) begin
                        state_d = MC_DONE;
                    end
                end
                MC_DONE: begin
                    state_d = MC_IDLE;
                end
                default: begin
                    state_d = MC_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        ex_multicycle_done_d = (state_d == MC_DONE);
        ex_busy_d            = (state_d != MC_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q              <= MC_IDLE;
            cnt_q                <= '0;
            ex_multicycle_done_q <= 1'b0;
            ex_busy_q            <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            ex_multicycle_done_q <= ex_multicycle_done_d;
            ex_busy_q            <= ex_busy_d;
        end
    end

    assign ex_multicycle_done = ex_multicycle_done_q;
    assign ex_busy            = ex_busy_q;

    // The accepting cycle itself is the first stalled cycle of the op.
    assign ex_req_eff = ex_stall_request | start_accept | (state_q == MC_BUSY);

    always_comb begin
        stall = STALL_NONE;
        if (!reset) begin
            stall = stall_vector(flush, if_stall_request, id_stall_request,
                                 ex_req_eff, mem_stall_request);
        end
    end

    assign stall_any = |stall;

    stall_sat_counter #(
        .WIDTH (PERF_WIDTH),
        .LIMIT ({PERF_WIDTH{1'b1}})
    ) u_perf (
        .clock  (clock),
        .reset  (reset),
        .clear  (perf_clear),
        .enable (stall_any),
        .count  (stall_cycles)
    );

    localparam int RUN_W = (WATCHDOG_LIMIT < 2) ? 1 : $clog2(WATCHDOG_LIMIT + 1);

    generate
        if (WATCHDOG_LIMIT > 0) begin : g_watchdog
            localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(WATCHDOG_LIMIT);
            logic [RUN_W-1:0] run_count;

            stall_sat_counter #(
                .WIDTH (RUN_W),
                .LIMIT (RUN_LIMIT)
            ) u_run (
                .clock  (clock),
                .reset  (reset),
                .clear  (~stall_any),
                .enable (stall_any),
                .count  (run_count)
            );

            // Flag in the same edge that takes the run counter to its limit.
            assign timeout_set = stall_any && (run_count >= (RUN_LIMIT - RUN_W'(1)));
        end else begin : g_no_watchdog
            assign timeout_set = 1'b0;
        end
    endgenerate

    assign stall_timeout_d = stall_timeout_q | timeout_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_timeout_q <= 1'b0;
        end else begin
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: priority, multi-cycle
// sequencing, flush abort, perf counter saturation and watchdog.
module tb_pipeline_stall_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic       if_stall_request;
    logic       id_stall_request;
    logic       ex_stall_request;
    logic       mem_stall_request;
    logic       ex_multicycle_start;
    logic [5:0] ex_multicycle_cycles;
    logic       ex_multicycle_done;
    logic       ex_busy;
    logic [5:0] stall;
    logic       perf_clear;
    logic [3:0] stall_cycles;
    logic       stall_timeout;

    always #5 clock = ~clock;

    pipeline_stall_controller #(
        .CYCLE_WIDTH    (6),
        .WATCHDOG_LIMIT (8),
        .PERF_WIDTH     (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .flush                (flush),
        .if_stall_request     (if_stall_request),
        .id_stall_request     (id_stall_request),
        .ex_stall_request     (ex_stall_request),
        .mem_stall_request    (mem_stall_request),
        .ex_multicycle_start  (ex_multicycle_start),
        .ex_multicycle_cycles (ex_multicycle_cycles),
        .ex_multicycle_done   (ex_multicycle_done),
        .ex_busy              (ex_busy),
        .stall                (stall),
        .perf_clear           (perf_clear),
        .stall_cycles         (stall_cycles),
        .stall_timeout        (stall_timeout)
    );

    typedef struct packed {
        logic [5:0] stall;
        logic       done;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] perf_q[$];
    logic       wd_q[$];
    int         checks = 0;
    int         errors = 0;

    logic [4:0] prio_stim [8];
    logic [5:0] prio_exp  [8];

    task automatic clear_inputs();
        flush                = 1'b0;
        if_stall_request     = 1'b0;
        id_stall_request     = 1'b0;
        ex_stall_request     = 1'b0;
        mem_stall_request    = 1'b0;
        ex_multicycle_start  = 1'b0;
        ex_multicycle_cycles = 6'd0;
        perf_clear           = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        mem_stall_request    = 1'b1;
        if_stall_request     = 1'b1;
        ex_multicycle_start  = 1'b1;
        ex_multicycle_cycles = 6'd4;
        exp_q.push_back('{stall: 6'b000000, done: 1'b0, busy: 1'b0});
        #2;
        e = exp_q.pop_front();
        checks++;
        if (stall !== e.stall) begin
            errors++;
            $display("FAIL reset_stall: got %b expected %b", stall, e.stall);
        end
        checks++;
        if ({ex_multicycle_done, ex_busy} !== {e.done, e.busy}) begin
            errors++;
            $display("FAIL reset_seq: got done=%b busy=%b expected done=%b busy=%b",
                     ex_multicycle_done, ex_busy, e.done, e.busy);
        end
        checks++;
        if ({stall_cycles, stall_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_counters: got cycles=%0d timeout=%b expected 0/0",
                     stall_cycles, stall_timeout);
        end
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        #2;
        checks++;
        if ({stall, ex_busy, ex_multicycle_done} !== 8'b0) begin
            errors++;
            $display("FAIL reset_release: got stall=%b busy=%b done=%b expected all 0",
                     stall, ex_busy, ex_multicycle_done);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        prio_stim = '{5'b10000, 5'b11000, 5'b11010, 5'b11011,
                      5'b00100, 5'b01100, 5'b00000, 5'b00110};
        prio_exp  = '{6'b000011, 6'b000111, 6'b011111, 6'b000000,
                      6'b001111, 6'b001111, 6'b000000, 6'b011111};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            {if_stall_request, id_stall_request, ex_stall_request,
             mem_stall_request, flush} = prio_stim[i];
            exp_q.push_back('{stall: prio_exp[i], done: 1'b0, busy: 1'b0});
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({stall, ex_multicycle_done, ex_busy} !== {e.stall, e.done, e.busy}) begin
                errors++;
                $display("FAIL priority[%0d]: got stall=%b done=%b busy=%b expected stall=%b done=%b busy=%b",
                         i, stall, ex_multicycle_done, ex_busy, e.stall, e.done, e.busy);
            end
        end
        clear_inputs();
    endtask

    task automatic test_multicycle(input int n);
        exp_t e;
        int   np;
        np = (n == 0) ? 1 : n;
        apply_reset();
        for (int k = 0; k <= np + 1; k++) begin
            @(negedge clock);
            ex_multicycle_start  = (k == 0) || ((np >= 3) && ((k == 2) || (k == np)));
            ex_multicycle_cycles = (k == 0) ? 6'(n) : 6'd9;
            exp_q.push_back('{stall: (k < np) ? 6'b001111 : 6'b000000,
                              done:  (k == np),
                              busy:  (k >= 1) && (k <= np)});
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({stall, ex_multicycle_done, ex_busy} !== {e.stall, e.done, e.busy}) begin
                errors++;
                $display("FAIL multicycle_n%0d[%0d]: got stall=%b done=%b busy=%b expected stall=%b done=%b busy=%b",
                         n, k, stall, ex_multicycle_done, ex_busy, e.stall, e.done, e.busy);
            end
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        exp_t e;
        logic [2:0] stim [7];
        logic [5:0] nval [7];
        exp_t       expv [7];
        // {flush, start}, op length, expected outputs per cycle
        stim = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000};
        nval = '{6'd5, 6'd0, 6'd0, 6'd2, 6'd0, 6'd0, 6'd0};
        expv = '{'{6'b001111, 1'b0, 1'b0}, '{6'b001111, 1'b0, 1'b1},
                 '{6'b000000, 1'b0, 1'b1}, '{6'b001111, 1'b0, 1'b0},
                 '{6'b001111, 1'b0, 1'b1}, '{6'b000000, 1'b1, 1'b1},
                 '{6'b000000, 1'b0, 1'b0}};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            flush                = stim[k][2];
            ex_multicycle_start  = stim[k][1];
            ex_multicycle_cycles = nval[k];
            exp_q.push_back(expv[k]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if ({stall, ex_multicycle_done, ex_busy} !== {e.stall, e.done, e.busy}) begin
                errors++;
                $display("FAIL flush_abort[%0d]: got stall=%b done=%b busy=%b expected stall=%b done=%b busy=%b",
                         k, stall, ex_multicycle_done, ex_busy, e.stall, e.done, e.busy);
            end
        end
        clear_inputs();
    endtask

    task automatic test_perf();
        logic [3:0] e;
        apply_reset();
        for (int phase = 0; phase < 3; phase++) begin
            @(negedge clock);
            clear_inputs();
            case (phase)
                0: begin
                    repeat (10) begin mem_stall_request = 1'b1; @(negedge clock); end
                    perf_q.push_back(4'd10);
                end
                1: begin
                    mem_stall_request = 1'b1;
                    perf_clear        = 1'b1;
                    @(negedge clock);
                    perf_q.push_back(4'd0);
                end
                default: begin
                    repeat (20) begin id_stall_request = 1'b1; @(negedge clock); end
                    perf_q.push_back(4'd15);
                end
            endcase
            clear_inputs();
            #2;
            e = perf_q.pop_front();
            checks++;
            if (stall_cycles !== e) begin
                errors++;
                $display("FAIL perf_phase%0d: got %0d expected %0d", phase, stall_cycles, e);
            end
        end
    endtask

    task automatic test_watchdog();
        logic e;
        apply_reset();
        for (int k = 0; k < 19; k++) begin
            @(negedge clock);
            clear_inputs();
            mem_stall_request = (k < 7) || ((k >= 8) && (k < 16)) || (k == 17);
            flush             = (k == 17);
            wd_q.push_back(k >= 16);
            #2;
            e = wd_q.pop_front();
            checks++;
            if (stall_timeout !== e) begin
                errors++;
                $display("FAIL watchdog[%0d]: got %b expected %b", k, stall_timeout, e);
            end
        end
        apply_reset();
        wd_q.push_back(1'b0);
        #2;
        e = wd_q.pop_front();
        checks++;
        if (stall_timeout !== e) begin
            errors++;
            $display("FAIL watchdog_reset: got %b expected %b", stall_timeout, e);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_priority();
        test_multicycle(4);
        test_multicycle(0);
        test_multicycle(1);
        test_multicycle(63);
        test_flush();
        test_perf();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no end expected end");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Produces the 6-bit stall vector consumed by every inter-stage pipeline buffer: bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- Each buffer interprets the vector independently: buffer n/n+1 holds when stall[n] and stall[n+1] are both set; inserts a bubble when stall[n] is set and stall[n+1] is clear.
- Arbitrates per-stage stall requests and owns the EX multi-cycle operation sequencer (divide/multiply-accumulate), with done handshake.
- Also provides a stall-cycle performance counter and a stuck-pipeline watchdog.

Parameters:
- CYCLE_WIDTH, 6: width of the multi-cycle length input.
- WATCHDOG_LIMIT, 1024: consecutive stalled cycles before timeout. 0 disables the watchdog.
- PERF_WIDTH, 32: stall-cycle counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  exception/branch flush; overrides all requests.
- if_stall_request  in  1  instruction fetch not ready.
- id_stall_request  in  1  load-use hazard.
- ex_stall_request  in  1  generic EX hold (external to sequencer).
- mem_stall_request  in  1  data memory not ready.
- ex_multicycle_start  in  1  EX begins a multi-cycle operation.
- ex_multicycle_cycles  in  CYCLE_WIDTH  operation length N.
- ex_multicycle_done  out  1  one-cycle pulse; result valid, EX may advance.
- ex_busy  out  1  sequencer not IDLE.
- stall  out  `SIGNAL_BUS (6)  stall vector.
- perf_clear  in  1  zero the stall-cycle counter.
- stall_cycles  out  PERF_WIDTH  saturating count of cycles with stall != 0.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- stall is combinational (Mealy) from requests and registered sequencer state. Zero latency.
- Effective EX request is ex_stall_request OR (sequencer start-accepted or BUSY).
- Priority, highest stage wins:
  - mem: 011111
  - ex: 001111
  - id: 000111
  - if: 000011
  - none: 000000
- flush=1 forces stall=000000 regardless of requests.
- Sequencer FSM states: IDLE, BUSY, DONE. Internal cnt is CYCLE_WIDTH bits.
  - IDLE + start (flush=0): this cycle counts as stalled cycle 1. Let N' = max(N,1); cnt <= N'-1. Next state is BUSY if N'>1, else DONE.
  - BUSY: EX stall asserted; cnt <= cnt-1; go to DONE when cnt==1.
  - DONE: ex_multicycle_done=1; sequencer contributes no stall; next state IDLE. Higher-stage requests still apply.
  - Net effect: exactly N' stalled cycles, then the DONE cycle.
  - start while BUSY or DONE is ignored. Start in DONE is not accepted; a new op is accepted only from IDLE.
- ex_busy = (state != IDLE).
- flush in any state: next state IDLE, cnt <= 0, no done pulse. A start coincident with flush is dropped.
- stall_cycles:
  - Increments each cycle stall != 0; saturates at all-ones.
  - perf_clear has priority over increment; counter loads 0.
- Watchdog:
  - Run counter increments while stall != 0 and clears when stall == 0.
  - When the run counter reaches WATCHDOG_LIMIT, stall_timeout <= 1 and stays set until reset. flush does not clear it.
  - Run counter saturates at WATCHDOG_LIMIT.
- Reset values:
  - state IDLE, cnt 0, stall_cycles 0, run counter 0.
  - stall_timeout 0, ex_multicycle_done 0, ex_busy 0.
  - stall = 000000 during reset cycles, regardless of requests.
- Reset mid-operation aborts the sequencer; no done pulse is emitted afterwards.

Decomposition:
- macro.v gains:
  - STALL_NONE / STALL_IF / STALL_ID / STALL_EX / STALL_MEM vector constants.
  - MC_IDLE / MC_BUSY / MC_DONE state encodings (2-bit).
  - SIGNAL_BUS reused as-is.
- One sub-module, stall_sat_counter (parameterised width/limit; clear, enable, saturate). Instantiated for stall_cycles and for the watchdog run counter.

Test Plan:
- Priority: id=1 and if=1 together -> 000111. Add mem=1 -> 011111. Add flush=1 -> 000000.
- Multi-cycle N=4 started at cycle t:
  - stall=001111 on cycles t..t+3.
  - ex_multicycle_done=1 at t+4 with stall=000000.
  - ex_busy high t+1..t+4.
  - Second start at t+2 ignored.
- N=0 and N=1 both give exactly 1 stalled cycle, then done the next cycle. N=63 gives 63 stalled cycles.
- Flush at BUSY cycle t+2 of an N=5 op:
  - stall=000000 that cycle.
  - No done pulse ever.
  - ex_busy=0 from t+3.
  - A new start at t+3 is accepted.
- Perf counter:
  - 10 stalled cycles -> stall_cycles=10.
  - perf_clear coincident with a stall -> 0.
  - With PERF_WIDTH=4, 20 stalled cycles -> 15 (saturated).
- Watchdog with WATCHDOG_LIMIT=8:
  - mem request held 7 cycles, dropped 1, then held 8 -> stall_timeout rises after the 8th consecutive cycle, not earlier.
  - Remains 1 through a flush; clears only on reset.
